// File: rtl/imsic_msi_arbiter.sv
// Round-robin arbiter funnelling MSI requests from several sources into one
// AXI-lite setipnum_le write path, tracking each write response or timing it out.
module imsic_msi_arbiter #(
   parameter int unsigned NR_REQ                = 4,
   parameter int unsigned NR_IMSICS             = 4,
   parameter int unsigned NR_VS_FILES_PER_IMSIC = 1,
   parameter int unsigned NR_SRC                = 64,
   parameter int unsigned AXI_ADDR_WIDTH        = 64,
   parameter int unsigned AXI_DATA_WIDTH        = 64,
   parameter logic [63:0] IMSIC_BASE            = 64'h2400_0000,
   parameter logic [63:0] HART_STRIDE           = 64'h8000,
   parameter int unsigned TIMEOUT               = 256,
   localparam int unsigned NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC,
   localparam int unsigned NR_SRC_LEN    = $clog2(NR_SRC),
   localparam int unsigned IMSIC_W       = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
   localparam int unsigned FILE_W        = $clog2(NR_INTP_FILES),
   localparam int unsigned REQ_W         = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
   localparam int unsigned CNT_W         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic                                  i_clk,
   input  logic                                  ni_rst,
   input  logic [NR_REQ-1:0]                     i_req_valid,
   output logic [NR_REQ-1:0]                     o_req_ready,
   input  logic [NR_REQ-1:0][IMSIC_W-1:0]        i_req_imsic,
   input  logic [NR_REQ-1:0][FILE_W-1:0]         i_req_file,
   input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]     i_req_eiid,
   output logic [NR_REQ-1:0]                     o_done,
   output logic [NR_REQ-1:0]                     o_err,
   output logic                                  o_wr_valid,
   input  logic                                  i_wr_ready,
   output logic [AXI_ADDR_WIDTH-1:0]             o_wr_addr,
   output logic [AXI_DATA_WIDTH-1:0]             o_wr_data,
   input  logic                                  i_bvalid,
   output logic                                  o_bready,
   input  logic [1:0]                            i_bresp
);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitB} state_e;

   state_e                  state_q, state_d;
   logic [REQ_W-1:0]        ptr_q, ptr_d;
   logic [REQ_W-1:0]        gnt_q, gnt_d;
   logic [IMSIC_W-1:0]      imsic_q, imsic_d;
   logic [FILE_W-1:0]       file_q, file_d;
   logic [NR_SRC_LEN-1:0]   eiid_q, eiid_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NR_REQ-1:0]       done_q, done_d;
   logic [NR_REQ-1:0]       err_q, err_d;
   // Low during reset and the first cycle after it, so every output reads 0 in reset.
   logic                    active_q;

   logic                    gnt_found;
   logic [REQ_W-1:0]        gnt_idx;
   logic [REQ_W-1:0]        cand;
   logic                    req_ok;
   logic [IMSIC_W-1:0]      sel_imsic;
   logic [FILE_W-1:0]       sel_file;
   logic [NR_SRC_LEN-1:0]   sel_eiid;
   logic                    sel_bad;

   // Search starts one past the last grant, wrapping modulo NR_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NR_REQ; k++) begin
         cand = REQ_W'((32'(ptr_q) + k) % NR_REQ);
         if (!gnt_found && i_req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign req_ok    = active_q && (state_q == StIdle) && gnt_found;
   assign sel_imsic = i_req_imsic[gnt_idx];
   assign sel_file  = i_req_file[gnt_idx];
   assign sel_eiid  = i_req_eiid[gnt_idx];
   assign sel_bad   = (sel_eiid == '0) || (32'(sel_eiid) >= NR_SRC) ||
                      (32'(sel_file) >= NR_INTP_FILES) || (32'(sel_imsic) >= NR_IMSICS);

   always_comb begin
      o_req_ready = '0;
      if (req_ok) begin
         o_req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      imsic_d = imsic_q;
      file_d  = file_q;
      eiid_d  = eiid_q;
      cnt_d   = cnt_q;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         StIdle: begin
            if (req_ok) begin
               ptr_d   = gnt_idx;
               gnt_d   = gnt_idx;
               imsic_d = sel_imsic;
               file_d  = sel_file;
               eiid_d  = sel_eiid;
               // Rejected locally: report next cycle and stay free for another accept.
               if (sel_bad) begin
                  done_d[gnt_idx] = 1'b1;
                  err_d[gnt_idx]  = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (i_wr_ready) begin
               state_d = StWaitB;
               cnt_d   = '0;
            end
         end
         StWaitB: begin
            cnt_d = cnt_q + 1'b1;
            if (i_bvalid) begin
               done_d[gnt_q] = 1'b1;
               err_d[gnt_q]  = (i_bresp != 2'b00);
               state_d       = StIdle;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               done_d[gnt_q] = 1'b1;
               err_d[gnt_q]  = 1'b1;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         state_q  <= StIdle;
         ptr_q    <= REQ_W'(NR_REQ - 1);
         gnt_q    <= '0;
         imsic_q  <= '0;
         file_q   <= '0;
         eiid_q   <= '0;
         cnt_q    <= '0;
         done_q   <= '0;
         err_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         imsic_q  <= imsic_d;
         file_q   <= file_d;
         eiid_q   <= eiid_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         active_q <= 1'b1;
      end
   end

   always_comb begin
      o_wr_valid = (state_q == StIssue);
      o_wr_addr  = '0;
      o_wr_data  = '0;
      if (state_q == StIssue) begin
         o_wr_addr = AXI_ADDR_WIDTH'(IMSIC_BASE) +
                     AXI_ADDR_WIDTH'(imsic_q) * AXI_ADDR_WIDTH'(HART_STRIDE) +
                     (AXI_ADDR_WIDTH'(file_q) << 12);
         o_wr_data = AXI_DATA_WIDTH'(eiid_q);
      end
      // Ready in IDLE too so late responses after a timeout are drained.
      o_bready = active_q && ((state_q == StWaitB) || (state_q == StIdle));
   end

   assign o_done = done_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Directed bench for imsic_msi_arbiter: a negedge monitor checks grants, bus writes
// and completions against queues filled when each request is driven.
module tb_imsic_msi_arbiter;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][1:0]  req_imsic;
   logic [3:0][1:0]  req_file;
   logic [3:0][5:0]  req_eiid;
   logic [3:0]       done;
   logic [3:0]       err;
   logic             wr_valid;
   logic             wr_ready;
   logic [63:0]      wr_addr;
   logic [63:0]      wr_data;
   logic             bvalid;
   logic             bready;
   logic [1:0]       bresp;

   imsic_msi_arbiter dut (
      .i_clk       (clk),
      .ni_rst      (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_imsic (req_imsic),
      .i_req_file  (req_file),
      .i_req_eiid  (req_eiid),
      .o_done      (done),
      .o_err       (err),
      .o_wr_valid  (wr_valid),
      .i_wr_ready  (wr_ready),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .i_bvalid    (bvalid),
      .o_bready    (bready),
      .i_bresp     (bresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_acc = 0;

   int          exp_gnt[$];
   logic [63:0] exp_addr[$];
   logic [63:0] exp_data[$];
   int          exp_didx[$];
   bit          exp_derr[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] msi_addr(input int im, input int fi);
      return 64'h2400_0000 + 64'(im) * 64'h8000 + 64'(fi) * 64'h1000;
   endfunction

   task automatic drive(input int idx, input int im, input int fi, input int ei);
      req_imsic[idx] = 2'(im);
      req_file[idx]  = 2'(fi);
      req_eiid[idx]  = 6'(ei);
   endtask

   // Queue the expected grant, optional bus write and optional completion.
   task automatic expect_req(input int idx, input int im, input int fi, input int ei,
                             input bit wr, input bit fin, input bit e);
      exp_gnt.push_back(idx);
      if (wr) begin
         exp_addr.push_back(msi_addr(im, fi));
         exp_data.push_back(64'(ei));
      end
      if (fin) begin
         exp_didx.push_back(idx);
         exp_derr.push_back(e);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(req_ready), 64'h0);
      check({tag, "_done"}, 64'(done), 64'h0);
      check({tag, "_err"}, 64'(err), 64'h0);
      check({tag, "_wvalid"}, 64'(wr_valid), 64'h0);
      check({tag, "_waddr"}, wr_addr, 64'h0);
      check({tag, "_wdata"}, wr_data, 64'h0);
      check({tag, "_bready"}, 64'(bready), 64'h0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      tick();
      check_all_zero("rst");
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && exp_didx.size() != 0; c++) tick();
      check("drain_done_q", 64'(exp_didx.size()), 64'h0);
   endtask

   int mon_g;
   int mon_i;
   bit mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if ((req_ready & req_valid) != 4'b0) begin
            n_acc++;
            if (exp_gnt.size() == 0) check("gnt_unexp", 64'(req_ready), 64'h0);
            else begin
               mon_g = exp_gnt.pop_front();
               check("gnt", 64'(req_ready), 64'(1) << mon_g);
            end
         end
         if (wr_valid && wr_ready) begin
            if (exp_addr.size() == 0) check("wr_unexp", wr_addr, 64'h0);
            else begin
               check("wr_addr", wr_addr, exp_addr.pop_front());
               check("wr_data", wr_data, exp_data.pop_front());
            end
         end
         if (done != 4'b0) begin
            if (exp_didx.size() == 0) check("done_unexp", 64'(done), 64'h0);
            else begin
               mon_i = exp_didx.pop_front();
               mon_e = exp_derr.pop_front();
               check("done", 64'(done), 64'(1) << mon_i);
               check("err", 64'(err), mon_e ? (64'(1) << mon_i) : 64'h0);
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      req_valid = '0;
      req_imsic = '0;
      req_file  = '0;
      req_eiid  = '0;
      wr_ready  = 1'b0;
      bvalid    = 1'b0;
      bresp     = 2'b00;
      rst_n     = 1'b0;
      #2;
      check_all_zero("rst_async");
      do_reset();

      // Single MSI with immediate bus responses: 3-cycle latency.
      wr_ready = 1'b1;
      bvalid   = 1'b1;
      bresp    = 2'b00;
      expect_req(0, 2, 1, 5, 1'b1, 1'b1, 1'b0);
      drive(0, 2, 1, 5);
      req_valid = 4'b0001;
      #1;
      check("t1_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      check("t1_wvalid", 64'(wr_valid), 64'h1);
      check("t1_waddr", wr_addr, 64'h2401_1000);
      check("t1_wdata", wr_data, 64'h5);
      tick();
      check("t1_bready", 64'(bready), 64'h1);
      check("t1_c2_done", 64'(done), 64'h0);
      tick();
      check("t1_done", 64'(done), 64'h1);
      check("t1_err", 64'(err), 64'h0);
      drain();

      // Fairness: all four continuously valid for eight MSIs.
      do_reset();
      for (int r = 0; r < 4; r++) drive(r, r, r % 3, 10 + r);
      for (int k = 0; k < 8; k++) expect_req(k % 4, k % 4, (k % 4) % 3, 10 + k % 4,
                                              1'b1, 1'b1, 1'b0);
      base = n_acc;
      req_valid = 4'b1111;
      for (int c = 0; c < 100 && n_acc < base + 8; c++) tick();
      req_valid = '0;
      check("fair_accepts", 64'(n_acc - base), 64'd8);
      drain();

      // Invalid requests are completed locally with an error, no bus write.
      for (int s = 0; s < 3; s++) begin
         int ei;
         int fi;
         ei = (s == 0) ? 0 : (s == 1) ? 64 : 5;
         fi = (s == 2) ? 3 : 0;
         expect_req(1, 0, fi, ei, 1'b0, 1'b1, 1'b1);
         drive(1, 0, fi, ei);
         req_valid = 4'b0010;
         #1;
         check("inv_ready", 64'(req_ready), 64'h2);
         tick();
         req_valid = '0;
         check("inv_done", 64'(done), 64'h2);
         check("inv_err", 64'(err), 64'h2);
         check("inv_wvalid", 64'(wr_valid), 64'h0);
      end
      tick();
      drain();

      // Back-pressure on the write channel, then a SLVERR response.
      wr_ready = 1'b0;
      bvalid   = 1'b0;
      tick();
      expect_req(2, 3, 2, 40, 1'b1, 1'b1, 1'b1);
      drive(2, 3, 2, 40);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         check("stall_wvalid", 64'(wr_valid), 64'h1);
         check("stall_waddr", wr_addr, 64'h2401_A000);
         check("stall_wdata", wr_data, 64'd40);
         tick();
      end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      bvalid   = 1'b1;
      bresp    = 2'b10;
      check("stall_bready", 64'(bready), 64'h1);
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      check("slverr_done", 64'(done), 64'h4);
      check("slverr_err", 64'(err), 64'h4);

      // Lost response: timeout, then a stale response in IDLE is discarded.
      wr_ready = 1'b1;
      expect_req(3, 0, 0, 1, 1'b1, 1'b1, 1'b1);
      drive(3, 0, 0, 1);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      n = 0;
      while (done == 4'b0 && n < 400) begin
         tick();
         n++;
      end
      check("to_cycles", 64'(n), 64'd256);
      check("to_done", 64'(done), 64'h8);
      check("to_err", 64'(err), 64'h8);
      bvalid = 1'b1;
      check("stale_bready", 64'(bready), 64'h1);
      tick();
      bvalid = 1'b0;
      check("stale_done", 64'(done), 64'h0);
      tick();
      check("stale_done2", 64'(done), 64'h0);
      wr_ready = 1'b1;
      bvalid   = 1'b1;
      expect_req(3, 1, 0, 7, 1'b1, 1'b1, 1'b0);
      drive(3, 1, 0, 7);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      tick();
      check("after_to_done", 64'(done), 64'h8);
      check("after_to_err", 64'(err), 64'h0);

      // Reset while waiting for a response: the MSI is dropped silently.
      bvalid = 1'b0;
      expect_req(0, 1, 1, 9, 1'b1, 1'b0, 1'b0);
      drive(0, 1, 1, 9);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      tick();
      check("wb_bready", 64'(bready), 64'h1);
      for (int r = 1; r < 4; r++) drive(r, r, 0, 20 + r);
      drive(0, 0, 2, 3);
      req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_wb");
      tick();
      bvalid = 1'b1;
      expect_req(0, 0, 2, 3, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 10 && req_ready == 4'b0; c++) tick();
      check("rst_first_gnt", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      drain();

      check("q_gnt_empty", 64'(exp_gnt.size()), 64'h0);
      check("q_wr_empty", 64'(exp_addr.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imsic_msi_arbiter.md
Name: imsic_msi_arbiter

Overview:
- Shares the single AXI-lite write path into imsic_top between NR_REQ MSI requesters (APLIC MSI domains, IOMMU, debug injector).
- Round-robin arbitration; one MSI in flight at a time.
- Each request is converted into a setipnum_le write at the address of the target IMSIC interrupt file, then the bus response is tracked to completion.
- Invalid requests are rejected locally; lost responses are covered by a timeout.

Parameters:
- NR_REQ, 4, number of requesters
- NR_IMSICS, 4, number of IMSICs (harts)
- NR_VS_FILES_PER_IMSIC, 1, guest files per IMSIC; NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC
- NR_SRC, 64, identities per file; NR_SRC_LEN = $clog2(NR_SRC)
- AXI_ADDR_WIDTH, 64, write address width
- AXI_DATA_WIDTH, 64, write data width
- IMSIC_BASE, 64'h2400_0000, base address of IMSIC 0, file 0
- HART_STRIDE, 64'h8000, address distance between IMSICs
- TIMEOUT, 256, maximum cycles spent in WAIT_B

Ports:
- i_clk  in  1  clock
- ni_rst  in  1  asynchronous active-low reset
- i_req_valid  in  NR_REQ  per-requester MSI request
- o_req_ready  out  NR_REQ  one-hot accept
- i_req_imsic  in  NR_REQ x $clog2(NR_IMSICS)  target IMSIC
- i_req_file  in  NR_REQ x $clog2(NR_INTP_FILES)  file: 0=M, 1=S, 2+ = VS n-2
- i_req_eiid  in  NR_REQ x NR_SRC_LEN  interrupt identity
- o_done  out  NR_REQ  one-cycle completion pulse
- o_err  out  NR_REQ  valid with o_done; request failed
- o_wr_valid  out  1  combined AW/W valid
- i_wr_ready  in  1  combined AW/W ready
- o_wr_addr  out  AXI_ADDR_WIDTH  write address
- o_wr_data  out  AXI_DATA_WIDTH  write data
- i_bvalid  in  1  write response valid
- o_bready  out  1  write response ready
- i_bresp  in  2  write response code

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - Round-robin pointer = NR_REQ-1, so requester 0 has highest priority first.
  - All outputs 0, timeout counter 0.
  - A request in flight is dropped silently; its requester must re-present it.
- FSM states: IDLE, ISSUE, WAIT_B.
- IDLE:
  - Grant the first valid requester at or after pointer+1, modulo NR_REQ.
  - o_req_ready[g] is combinationally high in the same cycle; at most one bit set.
  - The handshake latches imsic, file and eiid, and sets pointer = g.
  - No request valid: stay in IDLE.
- Validity check on the latched request:
  - Invalid if eiid == 0, eiid >= NR_SRC, file >= NR_INTP_FILES, or imsic >= NR_IMSICS.
  - Invalid request: no bus write; o_done[g] = o_err[g] = 1 in the next cycle; FSM stays in IDLE and may accept another request in that same cycle.
  - Valid request: go to ISSUE.
- ISSUE:
  - o_wr_valid = 1.
  - o_wr_addr = IMSIC_BASE + imsic*HART_STRIDE + file*4096. Computed at full AXI_ADDR_WIDTH; wraps modulo 2^AXI_ADDR_WIDTH.
  - o_wr_data = zero-extended eiid.
  - o_wr_valid, o_wr_addr and o_wr_data stay stable until i_wr_ready (AXI valid rule: valid is never withdrawn).
  - On the handshake go to WAIT_B and clear the counter.
- WAIT_B:
  - o_bready = 1; counter increments each cycle.
  - i_bvalid: o_done[g] = 1 next cycle; o_err[g] = (i_bresp != 2'b00); go to IDLE.
  - Counter reaches TIMEOUT-1 without i_bvalid: o_done[g] = o_err[g] = 1; go to IDLE.
  - i_bvalid in the same cycle as the timeout: the response wins; o_err follows i_bresp.
- Stale responses:
  - o_bready is also 1 in IDLE, to drain late responses after a timeout.
  - A response in IDLE is discarded; no o_done.
  - i_bvalid during ISSUE is not accepted (o_bready = 0).
- Latency, with immediate i_wr_ready and i_bvalid:
  - Accept at cycle 0, o_wr_valid at cycle 1, B handshake at cycle 2, o_done at cycle 3.
  - A new accept is possible at cycle 3: 3 cycles per MSI.
- Requester rules:
  - A requester holds valid and payload until ready.
  - A requester may drop valid while not granted, with no effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...

Test Plan:
- After reset, req0 with imsic=2, file=1, eiid=5; immediate ready/bvalid, bresp=0 -> o_wr_addr=0x2401_1000, o_wr_data=5, o_done[0] at cycle 3 with o_err[0]=0.
- All 4 requesters valid continuously for 8 MSIs -> grant order 0,1,2,3,0,1,2,3; exactly one o_req_ready bit at a time.
- Invalid requests: req1 with eiid=0, then eiid=64, then file=3 (NR_VS=1) -> no o_wr_valid; o_done[1]=o_err[1]=1 one cycle after each accept.
- i_wr_ready held low 10 cycles -> o_wr_valid, addr and data stable throughout; bresp=2'b10 -> o_err=1.
- Timeout: no bvalid -> o_done/o_err at cycle TIMEOUT after entering WAIT_B; a late bvalid in IDLE is accepted and discarded, and the next MSI completes normally.
- ni_rst asserted during WAIT_B -> all outputs 0 immediately; after release, req0 is granted first and no o_done is produced for the dropped MSI.
